// File: rtl/fifo_scheduler.sv
// ============================================================================
// fifo_scheduler : round-robin push arbiter and pop sequencer for a shared FIFO
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module fifo_scheduler #(
   parameter int NREQ = 4,
   parameter int DW   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ack,
   input  logic                 fifo_full,
   input  logic                 fifo_empty,
   output logic                 fifo_push,
   output logic [DW-1:0]        fifo_din,
   output logic                 fifo_pop,
   input  logic [DW-1:0]        fifo_dout,
   output logic                 out_valid,
   output logic [DW-1:0]        out_data,
   input  logic                 out_ready
);

   localparam int             PW        = $clog2(NREQ);
   localparam logic [PW-1:0]  LAST_INIT = PW'(NREQ - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_POP  = 2'd1,
      S_HOLD = 2'd2
   } pop_state_t;

   pop_state_t       state, state_nxt;
   logic             pop_nxt, valid_nxt, capture;
   logic [PW-1:0]    last, winner, idx;
   logic [NREQ-1:0]  eligible;
   logic             found, grant;
   logic [DW-1:0]    sel_data;

   always_comb begin
      state_nxt = state;
      pop_nxt   = 1'b0;
      valid_nxt = out_valid;
      capture   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop_nxt   = 1'b1;
               state_nxt = S_POP;
            end
         end
         // fifo_dout was refreshed by the pop on the intervening negedge
         S_POP: begin
            capture   = 1'b1;
            valid_nxt = 1'b1;
            state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) begin
               valid_nxt = 1'b0;
               if (!fifo_empty) begin
                  pop_nxt   = 1'b1;
                  state_nxt = S_POP;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            valid_nxt = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   // The requester acked last cycle still shows its old word, so mask it.
   always_comb begin
      eligible = req & ~req_ack;
      found    = 1'b0;
      winner   = last;
      idx      = last;
      for (int off = 1; off <= NREQ; off++) begin
         idx = PW'((int'(last) + off) % NREQ);
         if (!found && eligible[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
      grant    = found & ~fifo_full & ~pop_nxt;
      sel_data = req_data[int'(winner)*DW +: DW];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         fifo_pop  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         fifo_push <= 1'b0;
         fifo_din  <= '0;
         req_ack   <= '0;
         last      <= LAST_INIT;
      end else begin
         state     <= state_nxt;
         fifo_pop  <= pop_nxt;
         out_valid <= valid_nxt;
         if (capture) begin
            out_data <= fifo_dout;
         end
         fifo_push <= grant;
         req_ack   <= grant ? (NREQ'(1) << winner) : '0;
         if (grant) begin
            fifo_din <= sel_data;
            last     <= winner;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fifo_scheduler.sv
// ============================================================================
// tb_fifo_scheduler : randomized bench with a depth-10 FIFO and reference model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_fifo_scheduler;

   localparam int NREQ  = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 10;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic [NREQ-1:0]     req = '0;
   logic [NREQ*DW-1:0]  req_data = '0;
   logic [NREQ-1:0]     req_ack;
   logic                fifo_full, fifo_empty;
   logic                fifo_push, fifo_pop;
   logic [DW-1:0]       fifo_din;
   logic [DW-1:0]       fifo_dout = '0;
   logic                out_valid;
   logic [DW-1:0]       out_data;
   logic                out_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   fifo_scheduler #(.NREQ(NREQ), .DW(DW)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_ack(req_ack),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_push(fifo_push),
      .fifo_din(fifo_din), .fifo_pop(fifo_pop), .fifo_dout(fifo_dout),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // FIFO environment: one operation per negedge
   logic [DW-1:0] fq[$];
   int cnt = 0;
   assign fifo_full  = (cnt == DEPTH);
   assign fifo_empty = (cnt == 0);

   always @(negedge clk or negedge reset) begin
      if (!reset) begin
         fq.delete();
         fifo_dout = '0;
      end else if (fifo_push) begin
         if (fq.size() < DEPTH) fq.push_back(fifo_din);
      end else if (fifo_pop) begin
         if (fq.size() > 0) fifo_dout = fq.pop_front();
      end
      cnt = fq.size();
   end

   // Reference model: m_* are the values the registered outputs must take
   logic [NREQ-1:0] m_ack;
   logic            m_push, m_inflight, m_valid;
   logic [DW-1:0]   m_din;
   int              m_last;
   logic [DW-1:0]   sb[$];
   bit              p_pop, p_valid;
   int              p_w;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_ack = '0; m_push = 1'b0; m_din = '0;
         m_inflight = 1'b0; m_valid = 1'b0; m_last = NREQ - 1;
         sb.delete();
      end else begin
         // a pop goes out when none is in flight, the FIFO has data and the slot is or becomes free
         p_pop   = !m_inflight && !fifo_empty && (!m_valid || out_ready);
         p_valid = m_inflight || (m_valid && !out_ready);
         if (m_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
         p_w = -1;
         for (int k = 1; k <= NREQ; k++)
            if (p_w < 0 && req[(m_last + k) % NREQ] && !m_ack[(m_last + k) % NREQ])
               p_w = (m_last + k) % NREQ;
         if (p_w >= 0 && !fifo_full && !p_pop) begin
            m_push = 1'b1;
            m_din  = req_data[p_w*DW +: DW];
            m_ack  = NREQ'(1) << p_w;
            m_last = p_w;
            sb.push_back(m_din);
         end else begin
            m_push = 1'b0;
            m_ack  = '0;
         end
         m_inflight = p_pop;
         m_valid    = p_valid;
      end
   end

   always @(negedge clk) begin
      check("req_ack", {28'd0, req_ack}, {28'd0, m_ack});
      check("fifo_push", {31'd0, fifo_push}, {31'd0, m_push});
      check("fifo_pop", {31'd0, fifo_pop}, {31'd0, m_inflight});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("push_pop_excl", {31'd0, fifo_push & fifo_pop}, 32'd0);
      if (m_push) check("fifo_din", {24'd0, fifo_din}, {24'd0, m_din});
      if (m_valid) begin
         if (sb.size() > 0) check("out_data", {24'd0, out_data}, {24'd0, sb[0]});
         else begin
            checks++; errors++;
            $display("FAIL out_data: got 0x%0h expected no word at %0t", out_data, $time);
         end
      end
   end

   task automatic set_word(input int i, input logic [DW-1:0] v);
      req_data[i*DW +: DW] = v;
   endtask

   task automatic drain();
      bit done;
      req = '0; out_ready = 1'b1; done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk); #1;
         done = (sb.size() == 0) && !m_valid && !m_inflight && fifo_empty;
      end
      check("drain_done", {31'd0, done}, 32'd1);
   endtask

   int order[$];
   int pushes, acks, n;
   bit prev_push, seen;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end, required finish by %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      check("rst_req_ack", {28'd0, req_ack}, 32'd0);
      check("rst_fifo_push", {31'd0, fifo_push}, 32'd0);
      check("rst_fifo_pop", {31'd0, fifo_pop}, 32'd0);
      check("rst_fifo_din", {24'd0, fifo_din}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;

      // 1: all producers with fixed words, consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) set_word(i, DW'(8'h10 + i));
      req = '1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) if (req_ack[i]) order.push_back(i);
      end
      check("rr_len", {31'd0, order.size() >= 5}, 32'd1);
      if (order.size() >= 5) begin
         check("rr_0", order[0], 0); check("rr_1", order[1], 1);
         check("rr_2", order[2], 2); check("rr_3", order[3], 3);
         check("rr_4", order[4], 0);
      end
      drain();

      // 2: single requester alternates pushes
      req_data = '0; set_word(2, 8'h20); n = 0;
      pushes = 0; acks = 0; prev_push = 1'b0;
      req = 4'b0100;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("push_alternate", {31'd0, prev_push & fifo_push}, 32'd0);
         prev_push = fifo_push;
         pushes += int'(fifo_push);
         acks   += int'(req_ack[2]);
         #1;
         if (req_ack[2]) begin n++; set_word(2, DW'(8'h20 + n)); end
      end
      check("single_push_count", pushes, 5);
      check("single_push_eq_ack", pushes, acks);
      drain();

      // 3: consumer stalled fills FIFO plus one held word
      out_ready = 1'b0; acks = 0;
      for (int i = 0; i < NREQ; i++) set_word(i, DW'($urandom));
      req = '1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         acks += $countones(req_ack);
         #1;
         for (int i = 0; i < NREQ; i++) if (req_ack[i]) set_word(i, DW'($urandom));
      end
      check("stall_ack_count", acks, 11);
      check("stall_full", {31'd0, fifo_full}, 32'd1);
      out_ready = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk); #1;
         for (int i = 0; i < NREQ; i++) if (req_ack[i]) set_word(i, DW'($urandom));
      end
      drain();

      // 4: random traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk); #1;
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (req[i] && req_ack[i]) begin
               req[i] = ($urandom_range(0, 1) == 1);
               set_word(i, DW'($urandom));
            end else if (!req[i] && $urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
               set_word(i, DW'($urandom));
            end
         end
      end
      drain();

      // 5: quiet interface
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("quiet", {29'd0, fifo_pop, out_valid, |req_ack}, 32'd0);
      end

      // 6: asynchronous reset while holding a word with a push pending
      out_ready = 1'b0; req = 4'b0010; set_word(1, 8'h5a);
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk); #1;
         if (req_ack[1]) set_word(1, DW'($urandom));
         seen = out_valid && fifo_push;
      end
      check("hold_push_seen", {31'd0, seen}, 32'd1);
      #1 reset = 1'b0;
      #1 check("async_rst", {28'd0, out_valid, fifo_push, fifo_pop, |req_ack}, 32'd0);
      @(negedge clk); #1;
      for (int i = 0; i < NREQ; i++) set_word(i, DW'(8'h30 + i));
      req = '1; out_ready = 1'b1;
      reset = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (|req_ack) begin
            seen = 1'b1;
            check("first_ack_after_reset", {28'd0, req_ack}, 32'h1);
         end
      end
      check("ack_after_reset_seen", {31'd0, seen}, 32'd1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
